// File: rtl/reset_seq_pf_pkg.sv
// Shared types and sizing helpers for the sequenced PolarFire fabric reset block.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    // Sized so the larger terminal count fits; the counter clears at every terminal count.
    function automatic int cnt_width(input int min_hold, input int stage_dly);
        int m;
        m = (min_hold > stage_dly) ? min_hold : stage_dly;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_pf_if.sv
// Device-status inputs and reset outputs of reset_seq_pf grouped as one bundle.
interface reset_seq_pf_if #(
    parameter int N_CH  = 3,
    parameter int N_PLL = 1
);
    logic             BANK_x_VDDI_STATUS;
    logic             BANK_y_VDDI_STATUS;
    logic             FPGA_POR_N;
    logic [N_PLL-1:0] PLL_LOCK;
    logic             SS_BUSY;
    logic             INIT_DONE;
    logic             FF_US_RESTORE;
    logic             SOFT_RST;
    logic             PLL_POWERDOWN_B;
    logic [N_CH-1:0]  FABRIC_RESET_N;
    logic             RST_DONE;

    modport master (
        output BANK_x_VDDI_STATUS, BANK_y_VDDI_STATUS, FPGA_POR_N, PLL_LOCK,
               SS_BUSY, INIT_DONE, FF_US_RESTORE, SOFT_RST,
        input  PLL_POWERDOWN_B, FABRIC_RESET_N, RST_DONE
    );

    modport slave (
        input  BANK_x_VDDI_STATUS, BANK_y_VDDI_STATUS, FPGA_POR_N, PLL_LOCK,
               SS_BUSY, INIT_DONE, FF_US_RESTORE, SOFT_RST,
        output PLL_POWERDOWN_B, FABRIC_RESET_N, RST_DONE
    );

endinterface

// File: rtl/reset_seq_pf_sync_chain.sv
// Purpose: STAGES-deep single-bit synchroniser with asynchronous active-high clear.
// Latency: STAGES cycles from d to q.
// Backpressure: none.
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic INTERNAL_RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge CLK or posedge INTERNAL_RST) begin
        if (INTERNAL_RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq_pf.sv
// Purpose: qualify device readiness and release N_CH fabric resets in order after a hold time.
// Latency: channel k releases MIN_HOLD + k*STAGE_DLY cycles after synchronised ready rises.
// Backpressure: none; faults and SOFT_RST re-assert every channel at the next edge.
module reset_seq_pf
    import reset_seq_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int N_PLL       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HOLD    = 16,
    parameter int STAGE_DLY   = 4
) (
    input logic          CLK,
    input logic          EXT_RST,
    reset_seq_pf_if.slave bus
);

    localparam int CW = cnt_width(MIN_HOLD, STAGE_DLY);
    localparam int IW = $clog2(N_CH + 1);
    localparam logic [CW-1:0] HOLD_TC  = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] STAGE_TC = CW'(STAGE_DLY - 1);

    logic [N_PLL-1:0] pll_lock;
    logic             raw_rdy;
    logic             rdy_s;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [N_CH-1:0]  rel;

    assign pll_lock = bus.PLL_LOCK;
    assign raw_rdy  = ((bus.BANK_x_VDDI_STATUS & (&pll_lock)) | bus.SS_BUSY) & bus.INIT_DONE;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_rdy_sync (
        .CLK          (CLK),
        .INTERNAL_RST (EXT_RST),
        .d            (raw_rdy),
        .q            (rdy_s)
    );

    always_ff @(posedge CLK or posedge EXT_RST) begin
        if (EXT_RST) begin
            state <= HOLD;
            cnt   <= '0;
            idx   <= IW'(1);
            rel   <= '0;
        end else if (bus.SOFT_RST || !rdy_s) begin
            // Loss of readiness or a soft request overrides any release due this edge.
            state <= HOLD;
            cnt   <= '0;
            idx   <= IW'(1);
            rel   <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_TC) begin
                        rel[0] <= 1'b1;
                        cnt    <= '0;
                        idx    <= IW'(1);
                        state  <= (N_CH == 1) ? RUN : RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == STAGE_TC) begin
                        for (int k = 1; k < N_CH; k++) begin
                            if (idx == IW'(k)) rel[k] <= 1'b1;
                        end
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        if (idx == IW'(N_CH - 1)) state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    rel <= '1;
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                    idx   <= IW'(1);
                    rel   <= '0;
                end
            endcase
        end
    end

    // Restore bypass is a pure OR so the fabric sees it even while EXT_RST is held.
    assign bus.FABRIC_RESET_N  = rel | {N_CH{bus.FF_US_RESTORE}};
    assign bus.RST_DONE        = &rel;
    assign bus.PLL_POWERDOWN_B = bus.BANK_y_VDDI_STATUS & bus.FPGA_POR_N;

endmodule

// File: tb/tb_reset_seq_pf.sv
// Directed bench for reset_seq_pf with N_CH=3, N_PLL=2, MIN_HOLD=16, STAGE_DLY=4, SYNC_STAGES=2.
module tb_reset_seq_pf;

    logic clk;
    logic ext_rst;
    int   n_cmp;
    int   n_err;

    reset_seq_pf_if #(.N_CH(3), .N_PLL(2)) bus ();

    reset_seq_pf #(
        .N_CH        (3),
        .N_PLL       (2),
        .SYNC_STAGES (2),
        .MIN_HOLD    (16),
        .STAGE_DLY   (4)
    ) dut (
        .CLK     (clk),
        .EXT_RST (ext_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ext_rst                = 1'b1;
        bus.BANK_x_VDDI_STATUS = 1'b1;
        bus.BANK_y_VDDI_STATUS = 1'b1;
        bus.FPGA_POR_N         = 1'b1;
        bus.PLL_LOCK           = 2'b11;
        bus.SS_BUSY            = 1'b0;
        bus.INIT_DONE          = 1'b1;
        bus.FF_US_RESTORE      = 1'b0;
        bus.SOFT_RST           = 1'b0;
        step(3);

        // Reset state and restore bypass while EXT_RST is held
        chk("rst_frn",   32'(bus.FABRIC_RESET_N), 32'd0);
        chk("rst_done",  32'(bus.RST_DONE), 32'd0);
        chk("rst_rdy_s", 32'(dut.rdy_s), 32'd0);
        chk("rst_ppb",   32'(bus.PLL_POWERDOWN_B), 32'd1);
        bus.FF_US_RESTORE = 1'b1;
        #1;
        chk("ff_frn",  32'(bus.FABRIC_RESET_N), 32'd7);
        chk("ff_done", 32'(bus.RST_DONE), 32'd0);
        bus.FF_US_RESTORE = 1'b0;
        #1;
        chk("ff_off_frn", 32'(bus.FABRIC_RESET_N), 32'd0);

        // Power-up release: rdy_s at 2, channels at 18 / 22 / 26
        ext_rst = 1'b0;
        step(1);  chk("t1_rdy_s1",  32'(dut.rdy_s), 32'd0);
        step(1);  chk("t1_rdy_s2",  32'(dut.rdy_s), 32'd1);
        step(15); chk("t1_frn17",   32'(bus.FABRIC_RESET_N), 32'd0);
        step(1);  chk("t1_frn18",   32'(bus.FABRIC_RESET_N), 32'd1);
        step(3);  chk("t1_frn21",   32'(bus.FABRIC_RESET_N), 32'd1);
        step(1);  chk("t1_frn22",   32'(bus.FABRIC_RESET_N), 32'd3);
        step(3);  chk("t1_frn25",   32'(bus.FABRIC_RESET_N), 32'd3);
                  chk("t1_done25",  32'(bus.RST_DONE), 32'd0);
        step(1);  chk("t1_frn26",   32'(bus.FABRIC_RESET_N), 32'd7);
                  chk("t1_done26",  32'(bus.RST_DONE), 32'd1);

        // One-cycle PLL_LOCK[1] glitch in RUN
        step(2);
        bus.PLL_LOCK = 2'b01;
        step(1);
        bus.PLL_LOCK = 2'b11;
                  chk("t2_frn_p1",  32'(bus.FABRIC_RESET_N), 32'd7);
        step(1);  chk("t2_frn_p2",  32'(bus.FABRIC_RESET_N), 32'd7);
        step(1);  chk("t2_frn_p3",  32'(bus.FABRIC_RESET_N), 32'd0);
                  chk("t2_done_p3", 32'(bus.RST_DONE), 32'd0);
        step(15); chk("t2_frn_p18", 32'(bus.FABRIC_RESET_N), 32'd0);
        step(1);  chk("t2_frn_p19", 32'(bus.FABRIC_RESET_N), 32'd1);
        step(4);  chk("t2_frn_p23", 32'(bus.FABRIC_RESET_N), 32'd3);
        step(4);  chk("t2_frn_p27", 32'(bus.FABRIC_RESET_N), 32'd7);

        // One-cycle SOFT_RST in RUN
        step(2);
        bus.SOFT_RST = 1'b1;
        step(1);
        bus.SOFT_RST = 1'b0;
                  chk("t4_frn_q1",  32'(bus.FABRIC_RESET_N), 32'd0);
                  chk("t4_done_q1", 32'(bus.RST_DONE), 32'd0);
                  chk("t4_cnt_q1",  32'(dut.cnt), 32'd0);
        step(15); chk("t4_frn_q16", 32'(bus.FABRIC_RESET_N), 32'd0);
        step(1);  chk("t4_frn_q17", 32'(bus.FABRIC_RESET_N), 32'd1);

        // PLL_LOCK[0] glitch between channel 0 and channel 1 releases
        bus.PLL_LOCK = 2'b10;
        step(1);
        bus.PLL_LOCK = 2'b11;
                  chk("t3_frn_q18", 32'(bus.FABRIC_RESET_N), 32'd1);
        step(1);  chk("t3_frn_q19", 32'(bus.FABRIC_RESET_N), 32'd1);
        step(1);  chk("t3_frn_q20", 32'(bus.FABRIC_RESET_N), 32'd0);
                  chk("t3_cnt_q20", 32'(dut.cnt), 32'd0);
        step(1);  chk("t3_frn_q21", 32'(bus.FABRIC_RESET_N), 32'd0);
                  chk("t3_cnt_q21", 32'(dut.cnt), 32'd1);
        step(14); chk("t3_frn_q35", 32'(bus.FABRIC_RESET_N), 32'd0);
        step(1);  chk("t3_frn_q36", 32'(bus.FABRIC_RESET_N), 32'd1);
        step(8);  chk("t3_frn_q44", 32'(bus.FABRIC_RESET_N), 32'd7);
                  chk("t3_done_q44", 32'(bus.RST_DONE), 32'd1);

        // SOFT_RST held, then SOFT_RST landing on the release edge
        step(1);
        bus.SOFT_RST = 1'b1;
        step(20); chk("sh_frn",     32'(bus.FABRIC_RESET_N), 32'd0);
                  chk("sh_cnt",     32'(dut.cnt), 32'd0);
        bus.SOFT_RST = 1'b0;
        step(15); chk("sh_frn_s15", 32'(bus.FABRIC_RESET_N), 32'd0);
        bus.SOFT_RST = 1'b1;
        step(1);  chk("sw_frn_s16", 32'(bus.FABRIC_RESET_N), 32'd0);
        bus.SOFT_RST = 1'b0;
        step(15); chk("sw_frn_s31", 32'(bus.FABRIC_RESET_N), 32'd0);
        step(1);  chk("sw_frn_s32", 32'(bus.FABRIC_RESET_N), 32'd1);

        // EXT_RST mid-sequence aborts without waiting for a clock edge
        step(2);
        ext_rst = 1'b1;
        #1;
        chk("ab_frn", 32'(bus.FABRIC_RESET_N), 32'd0);
        chk("ab_cnt", 32'(dut.cnt), 32'd0);

        // SS_BUSY path qualifies ready with PLLs unlocked and bank x down
        bus.BANK_x_VDDI_STATUS = 1'b0;
        bus.PLL_LOCK           = 2'b00;
        bus.SS_BUSY            = 1'b1;
        step(2);
        ext_rst = 1'b0;
        step(17); chk("t6_frn17",  32'(bus.FABRIC_RESET_N), 32'd0);
        step(1);  chk("t6_frn18",  32'(bus.FABRIC_RESET_N), 32'd1);
        step(8);  chk("t6_frn26",  32'(bus.FABRIC_RESET_N), 32'd7);
                  chk("t6_done26", 32'(bus.RST_DONE), 32'd1);

        // PLL enable is combinational on bank y and POR
        bus.BANK_y_VDDI_STATUS = 1'b0;
        #1 chk("ppb_bank_y0", 32'(bus.PLL_POWERDOWN_B), 32'd0);
        bus.BANK_y_VDDI_STATUS = 1'b1;
        #1 chk("ppb_bank_y1", 32'(bus.PLL_POWERDOWN_B), 32'd1);
        bus.FPGA_POR_N = 1'b0;
        #1 chk("ppb_por0",    32'(bus.PLL_POWERDOWN_B), 32'd0);
        bus.FPGA_POR_N = 1'b1;

        // INIT_DONE low removes readiness regardless of SS_BUSY
        bus.INIT_DONE = 1'b0;
        step(2);  chk("id_frn2", 32'(bus.FABRIC_RESET_N), 32'd7);
        step(1);  chk("id_frn3", 32'(bus.FABRIC_RESET_N), 32'd0);
                  chk("id_done", 32'(bus.RST_DONE), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_seq_pf.md
Name: reset_seq_pf

Overview:
- Parametrised successor of the single-output PolarFire fabric reset block.
- Combines device-readiness status (VDDI, multiple PLL locks, INIT_DONE, SS_BUSY) into one synchronised "ready" condition.
- Releases N_CH active-low fabric reset channels in fixed order with programmable spacing, after a minimum hold time.
- Supports soft reset, fault re-assertion and the Flash*Freeze restore bypass; sits between the PolarFire init/PLL blocks and all fabric clock-domain logic on CLK.

Parameters:
- N_CH, 3: number of sequenced reset channels (>=1); channel 0 is released first.
- N_PLL, 1: number of PLL_LOCK inputs (>=1).
- SYNC_STAGES, 2: synchroniser depth for the ready condition (>=2).
- MIN_HOLD, 16: cycles the synchronised ready must be stable high before channel 0 releases (>=1).
- STAGE_DLY, 4: cycles between consecutive channel releases (>=1).

Ports:
- CLK  input  1  fabric clock.
- EXT_RST  input  1  asynchronous, active-high reset.
- BANK_x_VDDI_STATUS  input  1  I/O bank x supply good.
- BANK_y_VDDI_STATUS  input  1  I/O bank y supply good.
- FPGA_POR_N  input  1  device power-on reset, active-low.
- PLL_LOCK  input  N_PLL  per-PLL lock indication.
- SS_BUSY  input  1  system services busy.
- INIT_DONE  input  1  device initialisation complete.
- FF_US_RESTORE  input  1  Flash*Freeze user-state restore active.
- SOFT_RST  input  1  synchronous soft-reset request, sampled every cycle.
- PLL_POWERDOWN_B  output  1  PLL enable.
- FABRIC_RESET_N  output  N_CH  per-channel fabric reset, active-low.
- RST_DONE  output  1  high when all channels are released.

Behaviour:
- PLL_POWERDOWN_B = BANK_y_VDDI_STATUS & FPGA_POR_N; purely combinational, unaffected by EXT_RST.
- Raw ready = ((BANK_x_VDDI_STATUS & (&PLL_LOCK)) | SS_BUSY) & INIT_DONE.
- Raw ready passes through a SYNC_STAGES flop chain reset to 0; the chain output is rdy_s.
- EXT_RST high, asynchronously:
  - rel[N_CH-1:0] = 0, counter = 0, sync chain = 0, state = HOLD.
  - FABRIC_RESET_N = 0 unless FF_US_RESTORE is high.
  - RST_DONE = 0.
- FABRIC_RESET_N[k] = rel[k] | FF_US_RESTORE; the OR is combinational. FF_US_RESTORE does not affect the FSM or the counter.
- RST_DONE = &rel, registered via rel.
- HOLD state:
  - rel = 0.
  - Counter increments while rdy_s = 1 and clears when rdy_s = 0.
  - When the counter reaches MIN_HOLD-1 with rdy_s = 1: rel[0] <= 1, counter <= 0. Go to RELEASE with idx = 1, or to RUN if N_CH = 1.
- RELEASE state:
  - Counter increments each cycle.
  - At count STAGE_DLY-1: rel[idx] <= 1, counter <= 0, idx++. After rel[N_CH-1] is set, go to RUN.
- RUN state: all rel = 1; the counter is idle.
- Timing: rdy_s rises registered at cycle t.
  - rel[0] is high from cycle t+MIN_HOLD.
  - rel[k] is high from cycle t+MIN_HOLD+k*STAGE_DLY.
  - Raw ready to rdy_s adds SYNC_STAGES cycles.
- Fault or soft reset: in any state, rdy_s = 0 or SOFT_RST = 1 sampled at a CLK edge gives, at that edge:
  - rel <= 0 (all channels re-assert together, one cycle latency);
  - counter <= 0, idx <= 1, state <= HOLD.
- Re-release restarts the full MIN_HOLD sequence.
- Simultaneous events:
  - SOFT_RST wins over any release scheduled for the same edge.
  - SOFT_RST held high keeps the block in HOLD with the counter cleared.
- EXT_RST mid-sequence aborts immediately (asynchronous). Release starts from scratch after EXT_RST falls and rdy_s re-qualifies.
- Counter width: $clog2(max(MIN_HOLD, STAGE_DLY)+1); no wrap is possible because the counter clears at each terminal count.
- idx width: $clog2(N_CH+1).
- No X on outputs after reset.

Decomposition:
- Package reset_seq_pkg:
  - state enum {HOLD, RELEASE, RUN};
  - function cnt_width(MIN_HOLD, STAGE_DLY).
- One sub-module, reset_sync_chain: a parametrised SYNC_STAGES bit synchroniser with async active-high clear, reused for rdy_s.
- FSM, counter and output logic live in reset_seq_pf.

Test Plan (N_CH=3, MIN_HOLD=16, STAGE_DLY=4, SYNC_STAGES=2, N_PLL=2):
1. EXT_RST high, all status good. Release EXT_RST at cycle 0; inputs stay good.
   -> rdy_s at cycle 2; FABRIC_RESET_N = 001 at cycle 18, 011 at 22, 111 at 26; RST_DONE rises at 26.
2. In RUN, drop PLL_LOCK[1] for 1 cycle.
   -> FABRIC_RESET_N = 000 two-plus-one cycles later; RST_DONE = 0. After lock returns, the full 16/4/4 sequence repeats.
3. PLL_LOCK[0] drops after channel 0 is released but before channel 1.
   -> all channels re-assert; channels 1 and 2 never release during that attempt; the counter restarts from 0.
4. SOFT_RST pulsed for 1 cycle in RUN.
   -> FABRIC_RESET_N = 000 at the next edge; re-release of channel 0 exactly 16 cycles later (rdy_s stays high).
5. FF_US_RESTORE = 1 while EXT_RST = 1.
   -> FABRIC_RESET_N = 111 combinationally and RST_DONE = 0. When FF_US_RESTORE drops, FABRIC_RESET_N returns to 000.
6. SS_BUSY = 1 with PLL_LOCK = 00 and INIT_DONE = 1 -> sequence completes. Also toggle BANK_y_VDDI_STATUS -> PLL_POWERDOWN_B follows it with zero delay.
